imu_threshold_scheduler: RTL and testbench

// - Shares one signed threshold comparator among NCH IMU sample channels (e.g. accel X/Y/Z).
// - Sits between the per-axis filter outputs and the event/interrupt logic.
// - Per cycle-slot: round-robin grant of one channel, compare against that channel's threshold

---
 rtl/imu_pipe_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/imu_threshold_scheduler.sv | 145 ++++++++++++++
 tb/tb_imu_threshold_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_pipe_pkg.sv
// Shared widths, FSM state encoding and event record for the IMU threshold scheduler.
package imu_pipe_pkg;

  localparam int WIDTH = 16;
  localparam int NCH   = 3;
  localparam int CH_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            rise;
  } evt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel at or after the pointer,
// wrapping modulo NCH, and reports both a one-hot grant and its index.
module rr_arbiter
  import imu_pipe_pkg::*;
(
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  logic [CH_W:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, ptr_i} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(NCH)) begin
        cand = cand - (CH_W+1)'(NCH);
      end
      if (!found && req_i[cand[CH_W-1:0]]) begin
        found                  = 1'b1;
        idx_o                  = cand[CH_W-1:0];
        gnt_o[cand[CH_W-1:0]]  = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/imu_threshold_scheduler.sv
// Shares one signed threshold comparator among NCH IMU channels, applying per-channel
// hysteresis and debounce, and reports assert/release events through a valid/ready port.
module imu_threshold_scheduler
  import imu_pipe_pkg::*;
#(
  parameter int                       DEBOUNCE   = 3,
  parameter int                       CNT_W      = 4,
  parameter logic signed [WIDTH-1:0]  THRESH_RST = WIDTH'(100)
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_valid_i,
  input  logic [NCH*WIDTH-1:0]    ch_sample_i,
  output logic [NCH-1:0]          ch_ready_o,
  input  logic                    cfg_we_i,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [WIDTH-1:0]        cfg_thresh_i,
  input  logic [WIDTH-1:0]        cfg_hyst_i,
  output logic                    evt_valid_o,
  output logic [CH_W-1:0]         evt_ch_o,
  output logic                    evt_rise_o,
  input  logic                    evt_ready_i,
  output logic                    busy_o
);

  // Two guard bits keep thresh - hyst exact for any signed threshold and unsigned hysteresis.
  localparam int CW = WIDTH + 2;

  state_e state_q, state_d;
  logic [CH_W-1:0]          rrPtr_q;
  logic signed [WIDTH-1:0]  thresh_q [NCH];
  logic [WIDTH-1:0]         hyst_q   [NCH];
  logic [CNT_W-1:0]         cnt_q    [NCH];
  logic [NCH-1:0]           active_q;
  logic signed [WIDTH-1:0]  capSample_q;
  logic signed [WIDTH-1:0]  capThresh_q;
  logic [WIDTH-1:0]         capHyst_q;
  logic [CH_W-1:0]          capCh_q;
  evt_t                     evt_q;

  logic [NCH-1:0]   gnt;
  logic [CH_W-1:0]  gntIdx;
  logic             anyReq;
  logic             grantFire;
  logic             cfgHit;
  logic signed [CW-1:0] sampleX, threshX, releaseX;
  logic             above, below, qualify, curActive, toggle;
  logic [CNT_W-1:0] curCnt, cntInc;

  rr_arbiter u_arb (
    .req_i (ch_valid_i),
    .ptr_i (rrPtr_q),
    .gnt_o (gnt),
    .idx_o (gntIdx),
    .any_o (anyReq)
  );

  assign grantFire  = (state_q == ST_IDLE) && anyReq;
  assign ch_ready_o = grantFire ? gnt : '0;
  assign cfgHit     = cfg_we_i && ({1'b0, cfg_ch_i} < (CH_W+1)'(NCH));

  assign sampleX  = {{2{capSample_q[WIDTH-1]}}, capSample_q};
  assign threshX  = {{2{capThresh_q[WIDTH-1]}}, capThresh_q};
  assign releaseX = threshX - $signed({2'b00, capHyst_q});
  assign above    = sampleX > threshX;
  assign below    = sampleX < releaseX;

  assign curActive = active_q[capCh_q];
  assign curCnt    = cnt_q[capCh_q];
  assign cntInc    = curCnt + 1'b1;
  assign qualify   = curActive ? below : above;
  assign toggle    = (state_q == ST_CMP) && qualify && (cntInc == CNT_W'(DEBOUNCE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (anyReq) state_d = ST_CMP;
      ST_CMP:  state_d = toggle ? ST_EMIT : ST_IDLE;
      ST_EMIT: if (evt_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Grant-time snapshot: the compare never sees config writes that land after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q     <= '0;
      capSample_q <= '0;
      capThresh_q <= '0;
      capHyst_q   <= '0;
      capCh_q     <= '0;
      evt_q       <= '0;
    end else begin
      if (grantFire) begin
        capSample_q <= ch_sample_i[int'(gntIdx)*WIDTH +: WIDTH];
        capThresh_q <= thresh_q[gntIdx];
        capHyst_q   <= hyst_q[gntIdx];
        capCh_q     <= gntIdx;
        rrPtr_q     <= (gntIdx == CH_W'(NCH-1)) ? '0 : gntIdx + 1'b1;
      end
      if (toggle) begin
        evt_q.ch   <= capCh_q;
        evt_q.rise <= !curActive;
      end
    end
  end

  // Configuration writes come last so their counter clear overrides the compare update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        thresh_q[i] <= THRESH_RST;
        hyst_q[i]   <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      if (state_q == ST_CMP) begin
        if (toggle) begin
          active_q[capCh_q] <= !curActive;
          cnt_q[capCh_q]    <= '0;
        end else begin
          cnt_q[capCh_q]    <= qualify ? cntInc : '0;
        end
      end
      if (cfgHit) begin
        thresh_q[cfg_ch_i] <= cfg_thresh_i;
        hyst_q[cfg_ch_i]   <= cfg_hyst_i;
        cnt_q[cfg_ch_i]    <= '0;
      end
    end
  end

  assign evt_valid_o = (state_q == ST_EMIT);
  assign evt_ch_o    = evt_q.ch;
  assign evt_rise_o  = evt_q.rise;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imu_threshold_scheduler.sv
// Directed and randomized bench for imu_threshold_scheduler with a per-channel
// behavioural model of threshold, hysteresis, debounce and round-robin grant order.
module tb_imu_threshold_scheduler;
  import imu_pipe_pkg::*;

  localparam int DEB = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       ch_valid;
  logic [NCH*WIDTH-1:0] ch_sample;
  logic [NCH-1:0]       ch_ready;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [WIDTH-1:0]     cfg_thresh;
  logic [WIDTH-1:0]     cfg_hyst;
  logic                 evt_valid;
  logic [CH_W-1:0]      evt_ch;
  logic                 evt_rise;
  logic                 evt_ready;
  logic                 busy;

  int checks   = 0;
  int failures = 0;
  int dutEvts  = 0;

  int mThr  [NCH];
  int mHyst [NCH];
  int mCnt  [NCH];
  bit mAct  [NCH];
  int mPtr;

  always #5 clk = ~clk;

  imu_threshold_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .ch_valid_i   (ch_valid),
    .ch_sample_i  (ch_sample),
    .ch_ready_o   (ch_ready),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_thresh_i (cfg_thresh),
    .cfg_hyst_i   (cfg_hyst),
    .evt_valid_o  (evt_valid),
    .evt_ch_o     (evt_ch),
    .evt_rise_o   (evt_rise),
    .evt_ready_i  (evt_ready),
    .busy_o       (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NCH; i++) begin
      mThr[i] = 100; mHyst[i] = 0; mCnt[i] = 0; mAct[i] = 1'b0;
    end
    mPtr = 0;
  endfunction

  function automatic void modelCfg(input int c, input int t, input int h);
    if (c >= 0 && c < NCH) begin
      mThr[c] = t; mHyst[c] = h; mCnt[c] = 0;
    end
  endfunction

  function automatic int modelGrant(input logic [NCH-1:0] mask);
    int g = -1;
    for (int k = 0; k < NCH; k++) begin
      if (g < 0 && mask[(mPtr + k) % NCH]) g = (mPtr + k) % NCH;
    end
    if (g >= 0) mPtr = (g + 1) % NCH;
    return g;
  endfunction

  // A sample qualifies when it argues for leaving the current state; DEB in a row flips it.
  function automatic void modelStep(input int g, input int s, output bit evt, output bit rise);
    bit q;
    q = mAct[g] ? (s < mThr[g] - mHyst[g]) : (s > mThr[g]);
    mCnt[g] = q ? mCnt[g] + 1 : 0;
    evt = 1'b0;
    rise = 1'b0;
    if (mCnt[g] == DEB) begin
      mAct[g] = !mAct[g];
      mCnt[g] = 0;
      evt = 1'b1;
      rise = mAct[g];
    end
  endfunction

  task automatic cfgWrite(input int c, input int t, input int h);
    cfg_we = 1'b1; cfg_ch = CH_W'(c); cfg_thresh = WIDTH'(t); cfg_hyst = WIDTH'(h);
    tick();
    cfg_we = 1'b0;
    modelCfg(c, t, h);
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] mask, input int s0, input int s1, input int s2,
                               input bit cfgDuring = 1'b0, input int cfgC = 0,
                               input int cfgT = 0, input int cfgH = 0);
    int g, s;
    bit expEvt, expRise;
    logic [NCH-1:0] expOh;
    g = modelGrant(mask);
    s = (g == 0) ? s0 : ((g == 1) ? s1 : s2);
    expOh = '0;
    expOh[g] = 1'b1;
    modelStep(g, s, expEvt, expRise);
    ch_valid = mask;
    ch_sample = {WIDTH'(s2), WIDTH'(s1), WIDTH'(s0)};
    #1 checkOutput("grant", ch_ready, expOh);
    tick();
    ch_valid = '0;
    if (cfgDuring) begin
      cfg_we = 1'b1; cfg_ch = CH_W'(cfgC); cfg_thresh = WIDTH'(cfgT); cfg_hyst = WIDTH'(cfgH);
    end
    checkOutput("cmp_busy", busy, 1);
    checkOutput("cmp_no_ready", ch_ready, 0);
    tick();
    cfg_we = 1'b0;
    if (cfgDuring) modelCfg(cfgC, cfgT, cfgH);
    checkOutput("evt_valid", evt_valid, expEvt);
    if (evt_valid === 1'b1) dutEvts++;
    if (expEvt) begin
      checkOutput("evt_ch", evt_ch, g);
      checkOutput("evt_rise", evt_rise, expRise);
      if (evt_ready) begin
        tick();
        checkOutput("evt_done_idle", busy, 0);
      end
    end else begin
      checkOutput("no_evt_idle", busy, 0);
    end
  endtask

  task automatic sendN(input int ch, input int s, input int n);
    logic [NCH-1:0] m;
    m = '0;
    m[ch] = 1'b1;
    repeat (n) applyStimulus(m, s, s, s);
  endtask

  initial begin
    int b, g;
    bit e, r;
    logic [NCH-1:0] expOh;

    rst = 1'b1; ch_valid = '0; ch_sample = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_thresh = '0; cfg_hyst = '0; evt_ready = 1'b1;
    modelReset();
    tick(); tick();
    checkOutput("rst_ch_ready", ch_ready, 0);
    checkOutput("rst_evt_valid", evt_valid, 0);
    checkOutput("rst_evt_ch", evt_ch, 0);
    checkOutput("rst_evt_rise", evt_rise, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    $display("[TB] round-robin with all channels requesting");
    ch_valid = '1;
    ch_sample = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      expOh = '0;
      if (i % 2 == 0) begin
        g = modelGrant('1);
        modelStep(g, 0, e, r);
        expOh[(i / 2) % NCH] = 1'b1;
      end
      checkOutput($sformatf("rr_grant_%0d", i), ch_ready, expOh);
      checkOutput("rr_no_evt", evt_valid, 0);
      tick();
    end
    ch_valid = '0;

    $display("[TB] debounce on ch0 and ch2");
    b = dutEvts; sendN(0, 150, 3);
    checkOutput("debounce_rise_ch0", dutEvts - b, 1);
    b = dutEvts; sendN(2, 150, 1); sendN(2, 50, 1); sendN(2, 150, 1);
    checkOutput("debounce_broken_ch2", dutEvts - b, 0);

    $display("[TB] hysteresis on ch1");
    cfgWrite(1, 100, 20);
    sendN(1, 150, 3);
    b = dutEvts; sendN(1, 90, 3);
    checkOutput("hyst_hold_ch1", dutEvts - b, 0);
    b = dutEvts; sendN(1, 79, 3);
    checkOutput("hyst_fall_ch1", dutEvts - b, 1);

    $display("[TB] comparator boundaries on ch2");
    cfgWrite(2, 100, 0);
    b = dutEvts; sendN(2, 100, 3);
    checkOutput("equal_no_count", dutEvts - b, 0);
    cfgWrite(2, -32768, 10);
    sendN(2, 0, 3);
    b = dutEvts; sendN(2, -32768, 3);
    checkOutput("min_thresh_no_wrap", dutEvts - b, 0);

    $display("[TB] config writes during compare on ch1");
    b = dutEvts;
    sendN(1, 150, 1);
    applyStimulus(3'b010, 0, 150, 0, 1'b1, 1, 100, 20);
    sendN(1, 150, 2);
    checkOutput("cfg_clears_cnt", dutEvts - b, 0);
    sendN(1, 150, 1);
    checkOutput("cfg_then_rise", dutEvts - b, 1);
    b = dutEvts;
    sendN(1, 0, 2);
    applyStimulus(3'b010, 0, 0, 0, 1'b1, 1, -500, 0);
    checkOutput("cfg_keeps_result", dutEvts - b, 1);
    sendN(1, 0, 1);
    cfgWrite(3, 7, 7);

    $display("[TB] back-pressure on ch0 fall event");
    evt_ready = 1'b0;
    sendN(0, 0, 3);
    ch_valid = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_evt_valid", evt_valid, 1);
      checkOutput("bp_evt_ch", evt_ch, 0);
      checkOutput("bp_evt_rise", evt_rise, 0);
      checkOutput("bp_no_ready", ch_ready, 0);
    end
    ch_valid = '0;
    evt_ready = 1'b1;
    tick();
    checkOutput("bp_release_idle", busy, 0);

    $display("[TB] reset while an event is pending");
    cfgWrite(0, 500, 0);
    evt_ready = 1'b0;
    sendN(0, 600, 3);
    rst = 1'b1;
    #1;
    checkOutput("midrst_evt_valid", evt_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    modelReset();
    evt_ready = 1'b1;
    tick();
    b = dutEvts;
    repeat (7) applyStimulus('1, 101, 0, 0);
    checkOutput("thresh_back_to_100", dutEvts - b, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        cfgWrite(int'($urandom_range(0, 3)), int'($urandom_range(0, 250)) - 50,
                 int'($urandom_range(0, 60)));
      end else begin
        applyStimulus(NCH'($urandom_range(1, 7)),
                      int'($urandom_range(0, 500)) - 200,
                      int'($urandom_range(0, 500)) - 200,
                      int'($urandom_range(0, 500)) - 200,
                      ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 250)) - 50, int'($urandom_range(0, 60)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
